// File: rtl/shift_cmd_fifo.sv
// Command FIFO feeding the 8-bit barrel shifter: first-word-fall-through on the output side.
// Optional: define SHIFT_FIFO_OVF_EN to add the sticky ovf_flag backpressure debug output.

module shift_cmd_fifo_entry #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module shift_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SHW-1:0]           in_amt,
    input  logic                     in_lr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SHW-1:0]           out_amt,
    output logic                     out_lr,
    output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_FIFO_OVF_EN
    ,
    output logic                     ovf_flag
`endif
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        logic             lr;
    } cmd_t;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = $bits(cmd_t);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [DEPTH-1:0][EW-1:0]   mem;
    logic [DEPTH-1:0]           we;
    logic                       full, empty, push, pop;
    cmd_t                       in_cmd, head;

    // Flags come from the registered count only, so a pop cannot open
    // in_ready in the same cycle.
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign in_cmd.data = in_data;
    assign in_cmd.amt  = in_amt;
    assign in_cmd.lr   = in_lr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign we[gi] = push && (wr_ptr == AW'(gi));
            shift_cmd_fifo_entry #(.W(EW)) u_ent (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (we[gi]),
                .d     (in_cmd),
                .q     (mem[gi])
            );
        end
    endgenerate

    // Head is zeroed while empty so the shifter never sees a stale entry.
    assign head     = empty ? cmd_t'('0) : cmd_t'(mem[rd_ptr]);
    assign out_data = head.data;
    assign out_amt  = head.amt;
    assign out_lr   = head.lr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SHIFT_FIFO_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovf_flag <= 1'b0;
        else if (in_valid && !in_ready) ovf_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Bench for shift_cmd_fifo: directed scenarios plus random traffic against a queue model.
// Also covers ovf_flag when built with SHIFT_FIFO_OVF_EN.

module tb_shift_cmd_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic       in_lr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic       out_lr;
    logic [2:0] count;
`ifdef SHIFT_FIFO_OVF_EN
    logic       ovf_flag;
    bit         ovf_m = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [11:0] mq[$];

    always #5 clk = ~clk;

    shift_cmd_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_lr     (in_lr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .out_lr    (out_lr),
        .count     (count)
`ifdef SHIFT_FIFO_OVF_EN
        ,
        .ovf_flag  (ovf_flag)
`endif
    );

    function automatic logic [11:0] mhead();
        return (mq.size() != 0) ? mq[0] : 12'h000;
    endfunction

    // One clock: decide push/pop from the pre-edge model state, then advance.
    task automatic step();
        bit push, pop;
        logic [11:0] c;
        push = in_valid && (mq.size() < 4);
        pop  = out_ready && (mq.size() > 0);
        c    = {in_data, in_amt, in_lr};
`ifdef SHIFT_FIFO_OVF_EN
        if (in_valid && mq.size() == 4) ovf_m = 1'b1;
`endif
        @(posedge clk);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(c);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input logic [2:0] a, input logic l);
        in_valid = v; in_data = d; in_amt = a; in_lr = l;
    endtask

    task automatic drain();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({out_valid, in_ready, count, out_data, out_amt, out_lr} !== {1'b1 ^ 1'b1, 1'b1, 3'd0, 12'h000}) begin
            errors++;
            $display("FAIL reset_init got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=00",
                     out_valid, in_ready, count, out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 3'($urandom), 1'($urandom));
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
`ifdef SHIFT_FIFO_OVF_EN
        ovf_m = 1'b0;
`endif
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_flags got c=%0d v=%b r=%b want c=0 v=0 r=1", count, out_valid, in_ready);
        end
        vectors++;
        if ({out_data, out_amt, out_lr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_head got %h want 000", {out_data, out_amt, out_lr});
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 8'h80, 3'd4, 1'b1);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        vectors++;
        if ({out_valid, out_data, out_amt, out_lr, count} !== {1'b1, 8'h80, 3'd4, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single_head got v=%b d=%h a=%0d l=%b c=%0d want v=1 d=80 a=4 l=1 c=1",
                     out_valid, out_data, out_amt, out_lr, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, count, out_data} !== {1'b0, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL single_pop got v=%b c=%0d d=%h want v=0 c=0 d=00", out_valid, count, out_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 3'($urandom), 1'($urandom));
            step();
        end
        vectors++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got c=%0d r=%b want c=4 r=0", count, in_ready);
        end
        drive(1'b1, 8'h55, 3'd1, 1'b0);
        step(); step();
        vectors++;
        if (count !== 3'd4 || out_data !== 8'h01 || {out_data, out_amt, out_lr} !== mhead()) begin
            errors++;
            $display("FAIL fill_stall got c=%0d head=%h want c=4 head=%h", count,
                     {out_data, out_amt, out_lr}, mhead());
        end
`ifdef SHIFT_FIFO_OVF_EN
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        step();
        vectors++;
        if (ovf_flag !== 1'b1 || ovf_m !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", ovf_flag);
        end
`endif
        drive(1'b0, 8'h00, 3'd0, 1'b0);
    endtask

    // Starts full with 01..04 from test_fill.
    task automatic test_order_wrap();
        logic [11:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            exp = mhead();
            vectors++;
            if (out_data !== 8'(i) || {out_data, out_amt, out_lr} !== exp) begin
                errors++;
                $display("FAIL order_pop%0d got %h want %h", i, {out_data, out_amt, out_lr}, exp);
            end
            step();
        end
        out_ready = 1'b0;
        for (int i = 5; i <= 6; i++) begin
            drive(1'b1, 8'(i), 3'($urandom), 1'($urandom));
            step();
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            exp = mhead();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i) || {out_data, out_amt, out_lr} !== exp) begin
                errors++;
                $display("FAIL order_wrap%0d got v=%b %h want %h", i, out_valid,
                         {out_data, out_amt, out_lr}, exp);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL order_empty got v=%b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 8'hA1, 3'd1, 1'b0); step();
        drive(1'b1, 8'hA2, 3'd2, 1'b1); step();
        drive(1'b1, 8'hA3, 3'd3, 1'b0);
        out_ready = 1'b1;
        step();
        vectors++;
        if (count !== 3'd2 || out_data !== 8'hA2 || out_amt !== 3'd2 || out_lr !== 1'b1) begin
            errors++;
            $display("FAIL simul_mid got c=%0d d=%h a=%0d l=%b want c=2 d=A2 a=2 l=1",
                     count, out_data, out_amt, out_lr);
        end
        out_ready = 1'b0;
        drive(1'b1, 8'hA4, 3'd4, 1'b1); step();
        drive(1'b1, 8'hA5, 3'd5, 1'b0); step();
        drive(1'b1, 8'hEE, 3'd6, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_full_pop got c=%0d r=%b want c=3 r=1", count, in_ready);
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_data === 8'hEE || {out_data, out_amt, out_lr} !== mhead()) begin
                errors++;
                $display("FAIL simul_nopush got %h want %h", {out_data, out_amt, out_lr}, mhead());
            end
            step();
        end
        out_ready = 1'b0;
        drain();
    endtask

    task automatic test_shifter();
        logic [7:0] sh;
        drive(1'b1, 8'hFF, 3'd7, 1'b0);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            sh = out_lr ? (out_data << out_amt) : (out_data >> out_amt);
            vectors++;
            if (out_valid !== 1'b1 || sh !== 8'h01) begin
                errors++;
                $display("FAIL shifter_hookup got v=%b res=%h want v=1 res=01", out_valid, sh);
            end
            step();
        end
        drain();
    endtask

    task automatic test_random();
        logic [16:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) == 0);
            step();
            got = {out_valid, in_ready, count, out_data, out_amt, out_lr};
            exp = {mq.size() != 0, mq.size() < 4, 3'(mq.size()), mhead()};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d] got %h want %h", n, got, exp);
            end
        end
`ifdef SHIFT_FIFO_OVF_EN
        vectors++;
        if (ovf_flag !== ovf_m) begin
            errors++;
            $display("FAIL random_ovf got %b want %b", ovf_flag, ovf_m);
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_order_wrap();
        test_simultaneous();
        test_shifter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
